// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // Width of the mul/div occupancy down-counter.
  localparam int MD_CNT_W = 8;

  // Priority ranks; a lower value wins.
  localparam logic [1:0] PRIO_BRANCH = 2'd0;
  localparam logic [1:0] PRIO_MULDIV = 2'd1;
  localparam logic [1:0] PRIO_LW     = 2'd2;
  localparam logic [1:0] PRIO_NONE   = 2'd3;

  function automatic logic [1:0] pick_winner(input logic branch,
                                             input logic muldiv,
                                             input logic lw);
    if (branch)      return PRIO_BRANCH;
    else if (muldiv) return PRIO_MULDIV;
    else if (lw)     return PRIO_LW;
    else             return PRIO_NONE;
  endfunction

endpackage

// File: rtl/stall_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module stall_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Stall/flush scheduler: branch flush > mul/div hold > load-use bubble.
// Optional performance counters are built only when STALL_PERF_CNT_EN is defined.
module pipeline_stall_sequencer
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lw_stall_req,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  output logic             pcwrite,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             muldiv_done,
  output logic             busy,
  output logic [CNT_W-1:0] lw_stall_cnt,
  output logic [CNT_W-1:0] md_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t              state, state_next;
  logic [MD_CNT_W-1:0] cnt, cnt_next;
  logic [1:0]          winner;

  assign winner = pick_winner(branch_taken, muldiv_start, lw_stall_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pcwrite      = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    muldiv_done  = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          case (winner)
            PRIO_BRANCH: begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end
            PRIO_MULDIV: begin
              pcwrite      = 1'b0;
              if_id_write  = 1'b0;
              id_ex_write  = 1'b0;
              ex_mem_flush = 1'b1;
              cnt_next     = MD_CNT_W'(MULDIV_LAT - 1);
              state_next   = MD_WAIT;
            end
            PRIO_LW: begin
              pcwrite     = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end
            default: ;
          endcase
        end
        MD_WAIT: begin
          // EX is frozen here, so hazard inputs are not looked at.
          busy         = 1'b1;
          pcwrite      = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          cnt_next     = cnt - MD_CNT_W'(1);
          if (cnt == MD_CNT_W'(1)) begin
            muldiv_done = 1'b1;
            state_next  = RUN;
            cnt_next    = '0;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic lw_hit, md_hold, flush_hit;

  assign lw_hit    = !reset && (state == RUN) && (winner == PRIO_LW);
  assign flush_hit = !reset && (state == RUN) && (winner == PRIO_BRANCH);
  assign md_hold   = !reset && ((state == MD_WAIT) ||
                                ((state == RUN) && (winner == PRIO_MULDIV)));

  stall_sat_counter #(.W(CNT_W)) u_lw_cnt (
    .clk(clk), .clear(reset), .inc(lw_hit), .count(lw_stall_cnt)
  );
  stall_sat_counter #(.W(CNT_W)) u_md_cnt (
    .clk(clk), .clear(reset), .inc(md_hold), .count(md_stall_cnt)
  );
  stall_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .clear(reset), .inc(flush_hit), .count(flush_cnt)
  );
`else
  assign lw_stall_cnt = '0;
  assign md_stall_cnt = '0;
  assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer: a MULDIV_LAT=4 instance plus a
// MULDIV_LAT=2 instance sharing the same stimulus, both with 4-bit counters.
module tb_pipeline_stall_sequencer;

`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int CW = 4;

  // Output vector: {pcwrite, if_id_write, if_id_flush, id_ex_write,
  //                 id_ex_flush, ex_mem_flush, muldiv_done, busy}
  localparam logic [7:0] V_DEF  = 8'hD0;
  localparam logic [7:0] V_LW   = 8'h18;
  localparam logic [7:0] V_MD   = 8'h04;
  localparam logic [7:0] V_MDW  = 8'h05;
  localparam logic [7:0] V_DONE = 8'h07;
  localparam logic [7:0] V_BR   = 8'hF8;

  logic clk = 1'b0;
  logic reset, lw_stall_req, branch_taken, muldiv_start;

  logic pcw_a, ifw_a, iff_a, idw_a, idf_a, exf_a, done_a, busy_a;
  logic pcw_b, ifw_b, iff_b, idw_b, idf_b, exf_b, done_b, busy_b;
  logic [CW-1:0] lwc_a, mdc_a, flc_a, lwc_b, mdc_b, flc_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_stall_sequencer #(.MULDIV_LAT(4), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .lw_stall_req(lw_stall_req),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start),
    .pcwrite(pcw_a), .if_id_write(ifw_a), .if_id_flush(iff_a),
    .id_ex_write(idw_a), .id_ex_flush(idf_a), .ex_mem_flush(exf_a),
    .muldiv_done(done_a), .busy(busy_a),
    .lw_stall_cnt(lwc_a), .md_stall_cnt(mdc_a), .flush_cnt(flc_a)
  );

  pipeline_stall_sequencer #(.MULDIV_LAT(2), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .lw_stall_req(lw_stall_req),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start),
    .pcwrite(pcw_b), .if_id_write(ifw_b), .if_id_flush(iff_b),
    .id_ex_write(idw_b), .id_ex_flush(idf_b), .ex_mem_flush(exf_b),
    .muldiv_done(done_b), .busy(busy_b),
    .lw_stall_cnt(lwc_b), .md_stall_cnt(mdc_b), .flush_cnt(flc_b)
  );

  wire [7:0] out_a = {pcw_a, ifw_a, iff_a, idw_a, idf_a, exf_a, done_a, busy_a};
  wire [7:0] out_b = {pcw_b, ifw_b, iff_b, idw_b, idf_b, exf_b, done_b, busy_b};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk_cnts(input string tag, input int lw_e, input int md_e, input int fl_e);
    chk({tag, "_lwcnt"}, 8'(lwc_a), PERF ? 8'(lw_e) : 8'h00);
    chk({tag, "_mdcnt"}, 8'(mdc_a), PERF ? 8'(md_e) : 8'h00);
    chk({tag, "_flcnt"}, 8'(flc_a), PERF ? 8'(fl_e) : 8'h00);
  endtask

  initial begin
    reset = 1'b1; lw_stall_req = 1'b0; branch_taken = 1'b0; muldiv_start = 1'b0;
    next_cycle();
    next_cycle();
    // Requests during reset must not disturb the default outputs.
    muldiv_start = 1'b1; lw_stall_req = 1'b1;
    settle();
    chk("reset_forced_a", out_a, V_DEF);
    chk("reset_forced_b", out_b, V_DEF);
    next_cycle();
    muldiv_start = 1'b0; lw_stall_req = 1'b0; reset = 1'b0;
    settle();
    chk("idle_a", out_a, V_DEF);
    chk("idle_b", out_b, V_DEF);
    chk_cnts("idle", 0, 0, 0);

    // Single load-use bubble.
    next_cycle();
    lw_stall_req = 1'b1;
    settle();
    chk("lw_a", out_a, V_LW);
    next_cycle();
    lw_stall_req = 1'b0;
    settle();
    chk("lw_after_a", out_a, V_DEF);
    chk_cnts("lw", 1, 0, 0);

    // Mul/div window: 4 cycles on dut_a, 2 cycles on dut_b.
    next_cycle();
    muldiv_start = 1'b1;
    settle();
    chk("md_c1_a", out_a, V_MD);
    chk("md_c1_b", out_b, V_MD);
    next_cycle();
    muldiv_start = 1'b0;
    settle();
    chk("md_c2_a", out_a, V_MDW);
    chk("md_c2_b", out_b, V_DONE);
    next_cycle();
    settle();
    chk("md_c3_a", out_a, V_MDW);
    chk("md_c3_b", out_b, V_DEF);
    next_cycle();
    settle();
    chk("md_c4_a", out_a, V_DONE);
    next_cycle();
    settle();
    chk("md_after_a", out_a, V_DEF);
    chk_cnts("md", 1, 4, 0);
    chk("md_cnt_b", 8'(mdc_b), PERF ? 8'd2 : 8'd0);

    // All three sources at once: branch wins, nothing else happens.
    next_cycle();
    branch_taken = 1'b1; muldiv_start = 1'b1; lw_stall_req = 1'b1;
    settle();
    chk("all3_a", out_a, V_BR);
    chk("all3_b", out_b, V_BR);
    next_cycle();
    branch_taken = 1'b0; muldiv_start = 1'b0; lw_stall_req = 1'b0;
    settle();
    chk("all3_after_a", out_a, V_DEF);
    chk("all3_after_b", out_b, V_DEF);
    chk_cnts("all3", 1, 4, 1);

    // Reset arriving in the second cycle of a mul/div window.
    next_cycle();
    muldiv_start = 1'b1;
    settle();
    chk("mdrst_c1_a", out_a, V_MD);
    next_cycle();
    muldiv_start = 1'b0;
    settle();
    chk("mdrst_c2_a", out_a, V_MDW);
    reset = 1'b1;
    #1;
    chk("mdrst_forced_a", out_a, V_DEF);
    next_cycle();
    reset = 1'b0;
    settle();
    chk("mdrst_run_a", out_a, V_DEF);
    chk_cnts("mdrst", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      settle();
      chk("mdrst_nodone_a", out_a, V_DEF);
    end

    // 20 back-to-back bubbles against a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      lw_stall_req = 1'b1;
      settle();
      chk("lwsat_stall_a", out_a, V_LW);
    end
    next_cycle();
    lw_stall_req = 1'b0;
    settle();
    chk("lwsat_after_a", out_a, V_DEF);
    chk_cnts("lwsat", 15, 0, 0);
    chk("lwsat_cnt_b", 8'(lwc_b), PERF ? 8'd15 : 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_sequencer.md
# pipeline_stall_sequencer

Central stall/flush scheduler for the 5-stage pipeline. Arbitrates between three hazard sources: load-use stall requests from the load-use detector, taken-branch flushes resolved in EX, and multi-cycle mul/div occupancy of EX. Drives the PC and pipeline-register write-enable and flush controls, holding a counted multi-cycle stall window itself. Sits between the hazard detectors and the PC, IF/ID, ID/EX and EX/MEM registers.

## Interface
- MULDIV_LAT, 4, total EX occupancy in cycles of a mul/div op; legal range 2..255
- CNT_W, 16, width of performance counters
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- lw_stall_req  in  1  load-use hazard detected this cycle (one-cycle bubble request)
- branch_taken  in  1  branch in EX resolved taken this cycle
- muldiv_start  in  1  mul/div op present in EX this cycle (first cycle only)
- pcwrite  out  1  PC update enable
- if_id_write  out  1  IF/ID write enable
- if_id_flush  out  1  zero IF/ID on next edge
- id_ex_write  out  1  ID/EX write enable
- id_ex_flush  out  1  zero ID/EX control on next edge
- ex_mem_flush  out  1  zero EX/MEM control on next edge
- muldiv_done  out  1  pulse in final stall cycle of a mul/div window
- busy  out  1  high while in MD_WAIT
- lw_stall_cnt, md_stall_cnt, flush_cnt  out  CNT_W each  performance counters (see Configuration)

## Operation
- Defaults: pcwrite=1, if_id_write=1, id_ex_write=1, all flushes=0, muldiv_done=0.
- States: RUN, MD_WAIT. Outputs are Mealy (combinational from state and inputs).
- RUN uses fixed priority, highest first: branch_taken > muldiv_start > lw_stall_req.
  - branch_taken: if_id_flush=1, id_ex_flush=1, pcwrite=1. Lower-priority requests that cycle are dropped. Remain in RUN.
  - muldiv_start: pcwrite=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1. Load cnt=MULDIV_LAT-1. Go to MD_WAIT.
  - lw_stall_req: pcwrite=0, if_id_write=0, id_ex_flush=1. Remain in RUN. The detector deasserts itself once the bubble reaches EX.
- MD_WAIT: same hold outputs as muldiv_start, and cnt decrements each cycle.
  - When cnt==1: muldiv_done=1, next state RUN, cnt becomes 0.
  - lw_stall_req, branch_taken and muldiv_start are ignored. EX is frozen, so these cannot legally assert.
- cnt width is 8 bits. It never wraps, because it stops at 0 on entry to RUN.
- busy = (state==MD_WAIT).

## Timing
- Reset: state=RUN, cnt=0, counters=0. While reset=1, all outputs are forced to their defaults and busy=0.
- Mul/div stalls the front end for exactly MULDIV_LAT consecutive cycles: 1 in RUN plus MULDIV_LAT-1 in MD_WAIT. The first non-stalled cycle follows the muldiv_done cycle.
- A load-use stall lasts one cycle per asserted lw_stall_req cycle. The block adds no latency.
- A branch flush is applied in the same cycle as branch_taken.
- Reset asserted mid-MD_WAIT returns to RUN on the next edge. muldiv_done is not pulsed.
- If branch_taken and muldiv_start arrive in the same cycle, the branch wins and no MD_WAIT is entered. The mul/div in EX is on the wrong path.
- If MULDIV_LAT==2, MD_WAIT lasts exactly one cycle, and muldiv_done is asserted in that cycle.

## Configuration
- STALL_PERF_CNT_EN defined:
  - lw_stall_cnt increments each cycle the lw_stall_req branch is taken.
  - md_stall_cnt increments each cycle that mul/div hold outputs are active.
  - flush_cnt increments each branch flush.
  - All three saturate at 2^CNT_W-1 and are cleared by reset.
- STALL_PERF_CNT_EN undefined: the counter ports stay present and are tied to 0, and no counter flops are built.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, MD_WAIT)
  - the 8-bit cnt width constant
  - the priority-rank constants
- Sub-module stall_sat_counter (CNT_W-wide saturating incrementer with synchronous clear). It is instantiated three times, inside the STALL_PERF_CNT_EN guard only.

## Test plan
- Reset then idle: pcwrite=1, if_id_write=1, id_ex_write=1, all flushes=0, busy=0, counters=0.
- lw_stall_req for 1 cycle: that cycle pcwrite=0, if_id_write=0, id_ex_flush=1; next cycle back to defaults; lw_stall_cnt=1.
- muldiv_start with MULDIV_LAT=4: hold outputs for 4 cycles, busy=1 for cycles 2-4, muldiv_done only in cycle 4, md_stall_cnt=4.
- branch_taken, muldiv_start and lw_stall_req together: only if_id_flush=id_ex_flush=1 with pcwrite=1; no MD_WAIT entry; flush_cnt=1.
- reset asserted in MD_WAIT cycle 2: next cycle RUN with defaults, muldiv_done never pulses, counters=0.
- Preload counters near max (CNT_W=4) and apply 20 lw stalls: lw_stall_cnt stays at 15.
